// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 request scheduler: block width,
// default core latency and the in-flight tag carried alongside each block.
package aes_pkg;

    localparam int AES_W       = 128;  // AES block and key width
    localparam int AES_LATENCY = 21;   // default core pipeline depth
    localparam int ID_W_MAX    = 3;    // wide enough for 8 requesters

    // One entry of the in-flight tracker: a block is in the core and
    // belongs to requester id.
    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

    // Requester index k positions after base, wrapped into 0..n-1.
    function automatic int rr_index(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/aes_rsp_fifo.sv
// Result FIFO for the AES scheduler: first-word-fall-through, power-of-two
// depth, pointers wrap naturally. Head data/id read as zero while empty.
module aes_rsp_fifo
    import aes_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  ID_W  = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [AES_W-1:0] push_data,
    input  logic [ID_W-1:0]  push_id,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [AES_W-1:0] head_data,
    output logic [ID_W-1:0]  head_id,
    output logic [AW:0]      count
);

    logic [AES_W-1:0] mem_data [DEPTH];
    logic [ID_W-1:0]  mem_id   [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign head_valid = (count != '0);
    assign pop        = head_valid && pop_ready;
    assign head_data  = head_valid ? mem_data[rd_ptr] : '0;
    assign head_id    = head_valid ? mem_id[rd_ptr]   : '0;

    // Storage: written on push only; contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_id[wr_ptr]   <= push_id;
        end
    end

    // Pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/aes_128_sched.sv
// Round-robin scheduler in front of a non-stallable pipelined AES-128 core.
// Blocks are issued only while a FIFO slot is guaranteed for the result;
// a {valid,id} tag pipeline tracks each block until core_out is captured.
// Optional: define AES128_SCHED_STATS_EN to add stat_issued / stat_done.
module aes_128_sched
    import aes_pkg::*;
#(
    parameter int  NUM_REQ    = 2,
    parameter int  LATENCY    = AES_LATENCY,
    parameter int  FIFO_DEPTH = 4,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [AES_W*NUM_REQ-1:0] req_state,
    input  logic [AES_W*NUM_REQ-1:0] req_key,
    output logic [AES_W-1:0]         core_state,
    output logic [AES_W-1:0]         core_key,
    input  logic [AES_W-1:0]         core_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [AES_W-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id
`ifdef AES128_SCHED_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_done
`endif
);

    localparam int CW = $clog2(LATENCY + FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [ID_W-1:0]  start_ptr;   // first index searched this cycle
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  pick;
    logic             found;
    logic             credit_ok;
    logic             issue;
    logic [CW-1:0]    in_flight;
    logic [AW:0]      fifo_cnt;
    logic [CW:0]      occupancy;
    tag_t             iss_tag;
    tag_t [LATENCY:1] vld_pipe;
    logic             retire;
    logic [ID_W-1:0]  retire_id;
    logic             unused_tag_id;

    // Credits count every block that will need a FIFO slot: in the core or
    // already queued. A pop frees its credit only after the edge, so ready
    // never looks at rsp_ready. Reset forces ready low combinationally.
    assign occupancy = {1'b0, in_flight} + (CW+1)'(fifo_cnt);
    assign credit_ok = rst_n && (occupancy < (CW+1)'(FIFO_DEPTH));

    // Round-robin search: first valid requester at or after start_ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'(rr_index(int'(start_ptr), k, NUM_REQ));
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign issue     = found && credit_ok;
    assign req_ready = issue ? (NUM_REQ'(1) << pick) : '0;

    // Core input mux: granted requester's block and key, zero when idle.
    always_comb begin
        core_state = '0;
        core_key   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue && (pick == ID_W'(i))) begin
                core_state = req_state[i*AES_W +: AES_W];
                core_key   = req_key[i*AES_W +: AES_W];
            end
        end
    end

    always_comb begin
        iss_tag.valid = issue;
        iss_tag.id    = ID_W_MAX'(pick);
    end

    // Arbiter pointer: next search starts just after the last grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_ptr <= '0;
        end else if (issue) begin
            start_ptr <= (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + ID_W'(1);
        end
    end

    // Tag pipeline mirrors the core; clearing it on reset drops any block
    // still inside the core so its stale output is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= iss_tag;
            for (int s = 2; s <= LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
            end
        end
    end

    assign retire        = vld_pipe[LATENCY].valid;
    assign retire_id     = ID_W'(vld_pipe[LATENCY].id);
    assign unused_tag_id = ^vld_pipe[LATENCY].id;

    // in_flight equals the number of valid tags in the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else begin
            case ({issue, retire})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: ;
            endcase
        end
    end

    aes_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .ID_W  (ID_W)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (retire),
        .push_data  (core_out),
        .push_id    (retire_id),
        .pop_ready  (rsp_ready),
        .head_valid (rsp_valid),
        .head_data  (rsp_data),
        .head_id    (rsp_id),
        .count      (fifo_cnt)
    );

`ifdef AES128_SCHED_STATS_EN
    // Free-running issue / completion counters, wrap at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_done   <= '0;
        end else begin
            if (issue)                  stat_issued <= stat_issued + 32'd1;
            if (rsp_valid && rsp_ready) stat_done   <= stat_done + 32'd1;
        end
    end
`endif

endmodule

// File: doc/aes_128_sched.md
AES_128_SCHED -- requirements
Module: aes_128_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter LATENCY, default 21, meaning cycles from the clock edge that samples the core inputs to the cycle in which core_out holds that result.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning result FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester block-request valid.
REQ-007 SHALL have port req_ready, output, NUM_REQ, per-requester grant, at most one bit high.
REQ-008 SHALL have port req_state, input, 128*NUM_REQ, plaintext per requester (requester i at bits 128i+127:128i).
REQ-009 SHALL have port req_key, input, 128*NUM_REQ, key per requester, same packing.
REQ-010 SHALL have port core_state, output, 128, plaintext to the pipelined AES-128 core.
REQ-011 SHALL have port core_key, output, 128, key to the core.
REQ-012 SHALL have port core_out, input, 128, core ciphertext.
REQ-013 SHALL have port rsp_valid, output, 1, result available.
REQ-014 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-015 SHALL have port rsp_data, output, 128, ciphertext.
REQ-016 SHALL have port rsp_id, output, $clog2(NUM_REQ) (min 1), originating requester index.

Function
REQ-017 SHALL issue (req_valid[i] && req_ready[i]) at most one block per cycle; core_state/core_key SHALL combinationally equal the granted requester's data, and SHALL be all-zero when nothing is issued.
REQ-018 SHALL arbitrate round-robin: search starts at the index after the last granted requester; after reset the search starts at index 0.
REQ-019 SHALL assert any req_ready only when the credit condition holds: in_flight + fifo_count < FIFO_DEPTH, so the non-stallable core can never overflow the FIFO.
REQ-020 SHALL track each issue with a LATENCY-stage shift register carrying {valid, id}; a valid tag leaving the last stage SHALL push core_out and that id into the FIFO on the same edge.
REQ-021 SHALL keep in_flight equal to the count of valid tags, so a simultaneous issue and retire leaves it unchanged.
REQ-022 SHALL present the FIFO head as rsp_valid/rsp_data/rsp_id (first-word-fall-through); pop on rsp_valid && rsp_ready; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-023 SHALL keep results in issue order; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 SHALL hold rsp_data/rsp_id stable while rsp_valid && !rsp_ready.
REQ-025 SHALL never grant a requester with req_valid low; ready SHALL not depend on rsp_ready of the same cycle (credits free on the edge after the pop).

Reset
REQ-026 SHALL, while rst_n=0: clear all tags, pointers, counters and the arbiter pointer; drive req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0.
REQ-027 SHALL discard blocks in flight when reset asserts mid-operation; the first issue after release SHALL be at least LATENCY cycles before any result, and stale core_out SHALL never be pushed.

Configuration
REQ-028 SHALL, when AES128_SCHED_STATS_EN is defined, add outputs stat_issued[31:0] and stat_done[31:0] counting issues and pops (wrap at 2^32, reset to 0); without the macro the ports and counters SHALL not exist.

Structure
REQ-029 SHALL place the AES block width (128), the default LATENCY, and the tag struct {valid, id} typedef in the shared package aes_pkg.
REQ-030 SHALL implement the result FIFO as the sub-module aes_rsp_fifo; the arbiter and tag pipeline SHALL stay in aes_128_sched.

Verification
REQ-031 SHALL check a single block: requester 0 sends key 000102030405060708090a0b0c0d0e0f with plaintext 00112233445566778899aabbccddeeff; rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a with rsp_id=0, exactly LATENCY+1 cycles after issue with rsp_ready=1.
REQ-032 SHALL check both requesters continuously valid: grants alternate 0,1,0,1; rsp_id order matches issue order.
REQ-033 SHALL check back-pressure: rsp_ready=0 with requests pending; exactly FIFO_DEPTH blocks are issued and then req_ready stays 0 indefinitely; after rsp_ready=1, all results arrive in order with none lost.
REQ-034 SHALL check a simultaneous push and pop at fifo_count=FIFO_DEPTH-1: count is unchanged and no overflow occurs.
REQ-035 SHALL check reset asserted 5 cycles after 3 issues: after release no rsp_valid occurs; a new issue returns its correct result after LATENCY+1 cycles.
REQ-036 SHALL check, with AES128_SCHED_STATS_EN defined, 10 blocks issued and popped: stat_issued=10 and stat_done=10.
